// File: rtl/spi_psram_writer.sv
// SPI-to-PSRAM write bridge: parses WRITE/STATUS commands from the SPI protocol
// wrapper, packs data bytes into 32-bit words, buffers them in a word FIFO and
// drains the FIFO to the memory interface in bursts of up to BURST_LEN words.
module spi_psram_writer #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pw_wdata,
  input  logic        pw_wcmd,
  input  logic        pw_wstb,
  input  logic        pw_end,
  output logic        pw_req,
  input  logic        pw_gnt,
  output logic [7:0]  pw_rdata,
  output logic        pw_rstb,
  output logic [31:0] mi_addr,
  output logic [6:0]  mi_len,
  output logic        mi_rw,
  output logic        mi_valid,
  input  logic        mi_ready,
  output logic [31:0] mi_wdata,
  input  logic        mi_wack,
  output logic        mi_wlast
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_STAT, P_DISC} pstate_t;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_DATA} mstate_t;

  pstate_t ps_q, ps_d;
  mstate_t ms_q, ms_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [13:0]   abuf_q, abuf_d;
  logic [23:0]   wbuf_q, wbuf_d;
  logic [21:0]   waddr_q, waddr_d;
  logic          flush_q, flush_d, err_q, err_d, ovf_q, ovf_d;
  logic          pw_req_q, pw_req_d;
  logic [LW-1:0] n_q, n_d, rem_q, rem_d, level_q, level_d, n_sel;
  logic [21:0]   mi_addr_q, mi_addr_d;
  logic [6:0]    mi_len_q, mi_len_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem [FIFO_DEPTH];
  logic          push, pop, busy, gnt_fire, addr_load;
  logic [31:0]   push_word;
  logic [7:0]    status;

  // Command parser, byte packing, sticky flags and status-read handshake
  always_comb begin
    ps_d      = ps_q;
    bcnt_d    = bcnt_q;
    abuf_d    = abuf_q;
    wbuf_d    = wbuf_q;
    flush_d   = flush_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    pw_req_d  = pw_req_q;
    push      = 1'b0;
    addr_load = 1'b0;
    push_word = {pw_wdata, wbuf_q};
    busy      = (level_q != '0) || flush_q || (ms_q != M_IDLE);
    gnt_fire  = pw_req_q && pw_gnt;
    status    = {busy, 5'b0, err_q, ovf_q};

    if (flush_q && (level_q == '0) && (ms_q == M_IDLE)) flush_d = 1'b0;

    // Status read clears sticky flags; any set later in this block wins.
    if (gnt_fire) begin
      err_d    = 1'b0;
      ovf_d    = 1'b0;
      pw_req_d = 1'b0;
      if (ps_q == P_STAT) ps_d = P_DISC;
    end

    if (pw_end) begin
      bcnt_d = 2'd0;
      if (level_q != '0) flush_d = 1'b1;
      ps_d = P_IDLE;
    end else if (pw_wstb && pw_wcmd) begin
      bcnt_d = 2'd0;
      if (level_q != '0) flush_d = 1'b1;
      case (pw_wdata)
        8'hE0:   ps_d = P_ADDR;
        8'hE1: begin
          ps_d     = P_STAT;
          pw_req_d = 1'b1;
        end
        default: ps_d = P_DISC;
      endcase
    end else if (pw_wstb) begin
      case (ps_q)
        P_ADDR: begin
          bcnt_d = bcnt_q + 2'd1;
          abuf_d = {abuf_q[5:0], pw_wdata};
          if (bcnt_q == 2'd2) begin
            bcnt_d = 2'd0;
            if (busy) begin
              ps_d  = P_DISC;
              err_d = 1'b1;
            end else begin
              ps_d      = P_DATA;
              addr_load = 1'b1;
            end
          end
        end
        P_DATA: begin
          // Shift in from the top so the first byte ends up in bits 7:0.
          bcnt_d = bcnt_q + 2'd1;
          wbuf_d = {pw_wdata, wbuf_q[23:8]};
          if (bcnt_q == 2'd3) begin
            if (level_q != DEPTH_L) push = 1'b1;
            else ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory burst FSM, FIFO pointers and write-address bookkeeping
  always_comb begin
    ms_d      = ms_q;
    n_d       = n_q;
    rem_d     = rem_q;
    mi_addr_d = mi_addr_q;
    mi_len_d  = mi_len_q;
    waddr_d   = waddr_q;
    n_sel     = (level_q >= BURST_L) ? BURST_L : level_q;
    pop       = (ms_q == M_DATA) && mi_wack;

    if (addr_load) waddr_d = {abuf_q, pw_wdata};

    case (ms_q)
      M_IDLE: begin
        if ((level_q >= BURST_L) || (flush_q && (level_q != '0))) begin
          ms_d      = M_REQ;
          n_d       = n_sel;
          rem_d     = n_sel;
          mi_len_d  = 7'(n_sel - LW'(1));
          mi_addr_d = waddr_q;
        end
      end
      M_REQ: begin
        if (mi_ready) ms_d = M_DATA;
      end
      M_DATA: begin
        if (mi_wack) begin
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            ms_d    = M_IDLE;
            waddr_d = waddr_q + 22'(n_q);
          end
        end
      end
      default: ms_d = M_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q      <= P_IDLE;
      ms_q      <= M_IDLE;
      bcnt_q    <= '0;
      waddr_q   <= '0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pw_req_q  <= 1'b0;
      n_q       <= '0;
      rem_q     <= '0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mi_addr_q <= '0;
      mi_len_q  <= '0;
    end else begin
      ps_q      <= ps_d;
      ms_q      <= ms_d;
      bcnt_q    <= bcnt_d;
      waddr_q   <= waddr_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      pw_req_q  <= pw_req_d;
      n_q       <= n_d;
      rem_q     <= rem_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mi_addr_q <= mi_addr_d;
      mi_len_q  <= mi_len_d;
    end
  end

  // Byte assembly registers; contents are don't-care until bytes arrive
  always_ff @(posedge clk) begin
    abuf_q <= abuf_d;
    wbuf_q <= wbuf_d;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  assign pw_req   = pw_req_q;
  assign pw_rstb  = gnt_fire;
  assign pw_rdata = gnt_fire ? status : 8'h00;
  assign mi_addr  = {10'b0, mi_addr_q};
  assign mi_len   = mi_len_q;
  assign mi_rw    = 1'b0;
  assign mi_valid = (ms_q == M_REQ);
  assign mi_wdata = mem[rd_ptr_q];
  assign mi_wlast = (ms_q == M_DATA) && (rem_q == LW'(1));
endmodule

// File: tb/tb_spi_psram_writer.sv
// Bench for spi_psram_writer: directed SPI command streams, a transaction-level
// model of accepted words / write address / sticky flags, and a per-cycle
// monitor on the memory interface.
module tb_spi_psram_writer;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pw_wdata;
  logic        pw_wcmd, pw_wstb, pw_end, pw_req, pw_gnt, pw_rstb;
  logic [7:0]  pw_rdata;
  logic [31:0] mi_addr, mi_wdata;
  logic [6:0]  mi_len;
  logic        mi_rw, mi_valid, mi_ready, mi_wack, mi_wlast;

  always #5 clk = ~clk;

  spi_psram_writer #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb), .pw_end(pw_end),
    .pw_req(pw_req), .pw_gnt(pw_gnt), .pw_rdata(pw_rdata), .pw_rstb(pw_rstb),
    .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
    .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast)
  );

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  len;
    logic [31:0] w0;
  } burst_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  burst_t      blog[$];
  logic [21:0] mdl_addr = '0;
  logic [21:0] ma = '0;
  logic [31:0] mw = '0;
  bit          mdl_err = 1'b0, mdl_ovf = 1'b0;
  int          mps = 0;
  int          mcnt = 0;
  bit          in_data = 1'b0;
  int          rem = 0, nburst = 0;
  bit          prev_valid = 1'b0, prev_wlast = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [6:0]  prev_len = '0;
  int          wlast_rises = 0;
  bit          wack_on = 1'b0, wack_stall = 1'b0;
  int          wcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit mdl_busy();
    return (exp_q.size() != 0) || in_data;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte strobe; the model applies the parser rules to the same byte.
  task automatic send(input logic [7:0] b, input bit cmd);
    pw_wdata = b;
    pw_wcmd  = cmd;
    pw_wstb  = 1'b1;
    if (cmd) begin
      mcnt = 0;
      mps  = (b == 8'hE0) ? 1 : (b == 8'hE1) ? 3 : 4;
    end else if (mps == 1) begin
      ma = {ma[13:0], b};
      mcnt++;
      if (mcnt == 3) begin
        mcnt = 0;
        if (mdl_busy()) begin
          mps = 4;
          mdl_err = 1'b1;
        end else begin
          mps = 2;
          mdl_addr = ma;
        end
      end
    end else if (mps == 2) begin
      mw = {b, mw[31:8]};
      mcnt++;
      if (mcnt == 4) begin
        mcnt = 0;
        if (exp_q.size() == FIFO_DEPTH) mdl_ovf = 1'b1;
        else exp_q.push_back(mw);
      end
    end
    tick();
    pw_wstb = 1'b0;
    pw_wcmd = 1'b0;
  endtask

  task automatic end_txn();
    pw_end = 1'b1;
    mcnt = 0;
    mps = 0;
    tick();
    pw_end = 1'b0;
  endtask

  task automatic write_txn(input logic [23:0] a, input int nbytes, input logic [7:0] base, input bit do_end);
    send(8'hE0, 1'b1);
    send(a[23:16], 1'b0);
    send(a[15:8], 1'b0);
    send(a[7:0], 1'b0);
    for (int i = 0; i < nbytes; i++) send(base + 8'(i), 1'b0);
    if (do_end) end_txn();
  endtask

  task automatic status_read(input logic [7:0] lit);
    logic [7:0] expv;
    send(8'hE1, 1'b1);
    @(negedge clk);
    chk("req_set", 32'(pw_req), 32'd1);
    chk("rstb_wait", 32'(pw_rstb), 32'd0);
    tick();
    pw_gnt = 1'b1;
    @(negedge clk);
    expv = {mdl_busy(), 5'b0, mdl_err, mdl_ovf};
    chk("stat_rstb", 32'(pw_rstb), 32'd1);
    chk("stat_model", 32'(pw_rdata), 32'(expv));
    chk("stat_literal", 32'(pw_rdata), 32'(lit));
    mdl_err = 1'b0;
    mdl_ovf = 1'b0;
    tick();
    pw_gnt = 1'b0;
    @(negedge clk);
    chk("req_clear", 32'(pw_req), 32'd0);
    chk("rstb_one_cycle", 32'(pw_rstb), 32'd0);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_data || mi_valid) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL wait_idle: %0d words still expected after %0d cycles", exp_q.size(), n);
    end
    repeat (4) tick();
  endtask

  task automatic burst_lit(input int idx, input logic [31:0] a, input logic [6:0] l, input logic [31:0] w);
    if (blog.size() > idx) begin
      chk($sformatf("burst%0d_addr", idx), blog[idx].addr, a);
      chk($sformatf("burst%0d_len", idx), 32'(blog[idx].len), 32'(l));
      chk($sformatf("burst%0d_word0", idx), blog[idx].w0, w);
    end else begin
      checks++;
      failures++;
      $display("FAIL burst%0d_present: got %0d bursts required more than %0d", idx, blog.size(), idx);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pw_req"}, 32'(pw_req), 32'd0);
    chk({tag, "_pw_rstb"}, 32'(pw_rstb), 32'd0);
    chk({tag, "_pw_rdata"}, 32'(pw_rdata), 32'd0);
    chk({tag, "_mi_valid"}, 32'(mi_valid), 32'd0);
    chk({tag, "_mi_wlast"}, 32'(mi_wlast), 32'd0);
    chk({tag, "_mi_len"}, 32'(mi_len), 32'd0);
    chk({tag, "_mi_addr"}, mi_addr, 32'd0);
    chk({tag, "_mi_rw"}, 32'(mi_rw), 32'd0);
  endtask

  // Write-acknowledge driver: always-on or one ack every sixth cycle.
  initial begin
    mi_wack = 1'b0;
    forever begin
      tick();
      wcyc++;
      mi_wack = wack_stall ? (wcyc % 6 == 0) : wack_on;
    end
  end

  // Memory-interface monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      in_data    = 1'b0;
      prev_valid = 1'b0;
      prev_wlast = 1'b0;
      rem        = 0;
    end else begin
      if (mi_wlast && !prev_wlast) wlast_rises++;
      prev_wlast = mi_wlast;
      if (in_data) begin
        chk("valid_in_data", 32'(mi_valid), 32'd0);
        chk("wlast", 32'(mi_wlast), 32'(rem == 1));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wdata: word present on mi_wdata 0x%08h with none expected", mi_wdata);
        end else begin
          chk("wdata", mi_wdata, exp_q[0]);
          if (mi_wack) begin
            if (rem == nburst) blog[blog.size()-1].w0 = mi_wdata;
            void'(exp_q.pop_front());
            rem--;
            if (rem == 0) begin
              in_data  = 1'b0;
              mdl_addr = mdl_addr + 22'(nburst);
            end
          end
        end
      end else begin
        chk("wlast_idle", 32'(mi_wlast), 32'd0);
        if (mi_valid) begin
          chk("rw", 32'(mi_rw), 32'd0);
          if (prev_valid) begin
            chk("addr_stable", mi_addr, prev_addr);
            chk("len_stable", 32'(mi_len), 32'(prev_len));
          end
          if (mi_ready) begin
            chk("burst_addr", mi_addr, {10'b0, mdl_addr});
            chk("burst_len_range", 32'((int'(mi_len) < BURST_LEN) && (int'(mi_len) < exp_q.size())), 32'd1);
            blog.push_back('{addr: mi_addr, len: mi_len, w0: 32'hxxxxxxxx});
            nburst  = int'(mi_len) + 1;
            rem     = nburst;
            in_data = 1'b1;
          end
        end
      end
      prev_valid = mi_valid && !mi_ready;
      prev_addr  = mi_addr;
      prev_len   = mi_len;
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1;
    pw_wdata = 8'h00; pw_wcmd = 1'b0; pw_wstb = 1'b0; pw_end = 1'b0;
    pw_gnt = 1'b0; mi_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Grant without a request is ignored
    pw_gnt = 1'b1;
    @(negedge clk);
    chk("stray_gnt_rstb", 32'(pw_rstb), 32'd0);
    chk("stray_gnt_rdata", 32'(pw_rdata), 32'd0);
    tick();
    pw_gnt = 1'b0;

    // 128 bytes at 0x100, free-running memory side: two full bursts
    mi_ready = 1'b1; wack_on = 1'b1; blog.delete();
    write_txn(24'h000100, 128, 8'h00, 1'b1);
    wait_idle();
    chk("two_bursts", 32'(blog.size()), 32'd2);
    burst_lit(0, 32'h100, 7'd15, 32'h03020100);
    burst_lit(1, 32'h110, 7'd15, 32'h43424140);

    // 10 bytes at 0x20: two words flushed, trailing bytes dropped
    blog.delete();
    write_txn(24'h000020, 10, 8'hA0, 1'b1);
    wait_idle();
    chk("short_bursts", 32'(blog.size()), 32'd1);
    burst_lit(0, 32'h20, 7'd1, 32'hA3A2A1A0);
    status_read(8'h00);

    // Memory stalled, 140 bytes: FIFO fills, overflow flagged
    mi_ready = 1'b0; blog.delete();
    write_txn(24'h000300, 140, 8'h10, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("stalled_valid", 32'(mi_valid), 32'd1);
    chk("stalled_len", 32'(mi_len), 32'd15);
    chk("stalled_addr", mi_addr, 32'h300);
    chk("model_full", 32'(exp_q.size()), 32'd32);
    tick();
    status_read(8'h81);
    status_read(8'h80);
    mi_ready = 1'b1;
    wait_idle();
    burst_lit(0, 32'h300, 7'd15, 32'h13121110);
    burst_lit(1, 32'h310, 7'd15, 32'h53525150);

    // Second write while first burst is pending: error, data ignored
    mi_ready = 1'b0; blog.delete();
    write_txn(24'h000040, 8, 8'h60, 1'b1);
    write_txn(24'h000080, 8, 8'h70, 1'b1);
    status_read(8'h82);
    mi_ready = 1'b1;
    wait_idle();
    chk("err_bursts", 32'(blog.size()), 32'd1);
    burst_lit(0, 32'h40, 7'd1, 32'h63626160);
    status_read(8'h00);

    // Write-ack stalled between words
    wack_stall = 1'b1; blog.delete(); wlast_rises = 0;
    write_txn(24'h000030, 12, 8'hC0, 1'b1);
    wait_idle();
    burst_lit(0, 32'h30, 7'd2, 32'hC3C2C1C0);
    chk("wlast_once", 32'(wlast_rises), 32'd1);

    // Reset in the middle of a burst
    blog.delete();
    write_txn(24'h000200, 64, 8'h20, 1'b0);
    begin
      int n = 0;
      while (!in_data && n < 200) begin
        tick();
        n++;
      end
      chk("reached_data_phase", 32'(in_data), 32'd1);
    end
    repeat (8) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midburst");
    rst = 1'b0;
    exp_q.delete(); blog.delete();
    mdl_err = 1'b0; mdl_ovf = 1'b0; mdl_addr = '0; mps = 0; mcnt = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(mi_valid), 32'd0);
      tick();
    end
    wack_stall = 1'b0;
    write_txn(24'h000000, 64, 8'h80, 1'b1);
    wait_idle();
    chk("post_rst_bursts", 32'(blog.size()), 32'd1);
    burst_lit(0, 32'h0, 7'd15, 32'h83828180);
    status_read(8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
